i2c_reg_seq: RTL
================

Name: i2c_reg_seq

Overview:
- Parametrised successor of the fixed-function BMP180 ID-read sequencer. It executes one register transaction per command: either a burst read of N bytes, or a single-byte register write.
- Targets any 7-bit I2C device. It drives the existing I2C master through the start/send/receive/sended/received handshake.
- Received bytes are stored in an internal buffer with a random-access readout port.
- Adds command handshake, length checking, a per-step timeout with error reporting, and a done pulse.

Parameters:
- DEV_ADDR, 7'h77: 7-bit I2C device address.
- MAX_LEN, 22: receive buffer depth in bytes; legal read length is 1..MAX_LEN.
- LW, 5: width of length/index fields; must satisfy 2^LW > MAX_LEN.
- START_HOLD, 15: cycles that `start` stays high after a start/restart byte is presented.
- TIMEOUT, 16'hFFFF: cycles allowed in any wait state before abort.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only
- cmd_write  in  1  1 = write, 0 = burst read
- cmd_reg  in  8  register address
- cmd_len  in  LW  read byte count (ignored on write)
- cmd_wdata  in  8  write data byte
- isReady  in  1  master idle
- start  out  1  byte carries START/RESTART
- send  out  1  one-cycle request for next send slot
- datasend  out  8  address/data byte to master
- sended  in  1  master send-accept level
- receive  out  1  one-cycle request for next receive slot
- datareceive  in  8  byte from master
- received  in  1  master byte-valid level
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at end of a transaction
- err  out  1  sticky error flag, cleared by next accepted command
- rx_count  out  LW  bytes stored by last transaction
- rd_addr  in  LW  buffer read index
- rd_data  out  8  buffer[rd_addr], or 0 if rd_addr >= MAX_LEN (combinational)

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. Buffer cleared to 0, state IDLE, edge registers 0, counters 0.
- Reset mid-transaction: aborts on the next edge. No done pulse, and the master is left to recover via its own isReady.
- Command accept: cmd_valid && cmd_ready at edge T latches the command; busy = 1 and cmd_ready = 0 from T+1.
- Read with cmd_len = 0 or cmd_len > MAX_LEN is rejected: done and err both pulse at T+1, busy stays 0, no bus activity.
- Send list:
  - Read: {DEV_ADDR,0} with start=1; cmd_reg with start=0; {DEV_ADDR,1} with start=1 (restart).
  - Write: {DEV_ADDR,0} with start=1; cmd_reg; cmd_wdata.
- Edge detection: sended and received are each compared with a registered copy. Rise and fall are each detected one cycle after the input changes.
- States:
  - IDLE
  - WAIT_RDY: exits when isReady = 1.
  - PRESENT (1 cycle): drives datasend. If the byte is a start byte, loads the start-hold counter.
  - TX_ACC: waits for sended rise.
  - TX_REL: waits for sended fall. If more bytes remain, advance the pointer, go to SEND_REQ (send = 1 for exactly one cycle), then PRESENT. After the last byte: a write goes to DONE; a read goes to RX_ACC.
  - RX_ACC: on received rise, store datareceive into buf[idx] and increment idx.
  - RX_REL: on received fall, if idx < len go to RX_REQ (receive = 1 for one cycle) then back to RX_ACC; otherwise go to DONE.
  - DONE (1 cycle): done = 1, rx_count = idx, then IDLE.
- datasend is 0 outside PRESENT..TX_REL.
- start = 1 only while the current byte is a start byte and the hold counter < START_HOLD; it drops immediately on sended rise.
- Timeout: a counter restarts on every state change. Reaching TIMEOUT in WAIT_RDY, TX_ACC, TX_REL, RX_ACC or RX_REL sets err, goes to DONE, and pulses done. rx_count then holds the bytes stored so far.
- Ignored events:
  - Extra received edges outside RX states.
  - sended edges outside TX states.
  - cmd_valid while busy.
- Buffer entries beyond rx_count keep their previous values. idx never exceeds len, so there is no wrap.
- A sended rise in the same cycle as a timeout expiry: the timeout wins.

Decomposition:
- Shared package i2c_seq_pkg: state encoding, the START/RESTART/READ/WRITE bit constants, the default BMP180 address 7'h77, and register constants (ID 8'hD0, CALIB 8'hAA, CTRL 8'hF4, OUT 8'hF6).
- One natural sub-module: i2c_rx_buf, the MAX_LEN x 8 buffer with synchronous write, synchronous clear and combinational read.

Test Plan:
- Read ID: cmd read, reg D0, len 1; master model returns 8'h55 → datasend sequence EE, D0, EF with start = 1,0,1; one send pulse between each pair of bytes; buf[0] = 55; rx_count = 1; done without err.
- Calibration burst: reg AA, len 22, bytes 00..15 → rd_data[k] = k for k = 0..21; exactly 21 receive pulses; rx_count = 22.
- Write: cmd write, reg F4, data 2E → datasend EE, F4, 2E; no receive pulses; done; err = 0; buffer unchanged.
- Length check: len 0 and len 23 → done and err at T+1, busy never high, datasend stays 0.
- Timeout: master holds sended low after the first byte for TIMEOUT cycles → err = 1, done pulses, cmd_ready returns; the next accepted command clears err.
- Reset mid-read after 3 bytes received → outputs at reset values next cycle, rd_data = 0 for all addresses.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the parametrised I2C register sequencer and its buffer.
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_PRESENT,
    ST_TX_ACC,
    ST_TX_REL,
    ST_SEND_REQ,
    ST_RX_ACC,
    ST_RX_REL,
    ST_RX_REQ,
    ST_DONE
  } seq_state_e;

  localparam logic START_BIT   = 1'b1;
  localparam logic RESTART_BIT = 1'b1;
  localparam logic READ_BIT    = 1'b1;
  localparam logic WRITE_BIT   = 1'b0;

  localparam logic [6:0] BMP180_ADDR = 7'h77;

  localparam logic [7:0] REG_ID    = 8'hD0;
  localparam logic [7:0] REG_CALIB = 8'hAA;
  localparam logic [7:0] REG_CTRL  = 8'hF4;
  localparam logic [7:0] REG_OUT   = 8'hF6;

  function automatic logic [7:0] addrByte(input logic [6:0] addr, input logic rw);
    return {addr, rw};
  endfunction

endpackage

// File: rtl/i2c_rx_buf.sv
// Receive byte store: synchronous write and clear, combinational read that
// returns 0 for indices past the end of the buffer.
module i2c_rx_buf #(
  parameter int MAX_LEN = 22,
  parameter int LW      = 5
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [LW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [LW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [MAX_LEN];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (int'(waddr_i) < MAX_LEN)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (int'(raddr_i) < MAX_LEN) begin
      rdata_o = mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/i2c_reg_seq.sv
// One-command-at-a-time I2C register sequencer: burst read into a local buffer
// or single-byte write, driving the existing master's send/receive handshake.
module i2c_reg_seq
  import i2c_seq_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = BMP180_ADDR,
  parameter int          MAX_LEN    = 22,
  parameter int          LW         = 5,
  parameter int          START_HOLD = 15,
  parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [7:0]    cmd_reg,
  input  logic [LW-1:0] cmd_len,
  input  logic [7:0]    cmd_wdata,
  input  logic          isReady,
  output logic          start,
  output logic          send,
  output logic [7:0]    datasend,
  input  logic          sended,
  output logic          receive,
  input  logic [7:0]    datareceive,
  input  logic          received,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [LW-1:0] rx_count,
  input  logic [LW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  seq_state_e    state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] rxCount_q, rxCount_d;
  logic          err_q, err_d;
  logic [15:0]   holdCnt_q, holdCnt_d;
  logic [15:0]   toCnt_q, toCnt_d;
  logic          sended_q, received_q;
  logic          cmdWrite_q;
  logic [7:0]    cmdReg_q, cmdWdata_q;
  logic [LW-1:0] len_q;

  logic          accept, lenBad, waitState, timedOut, lastByte;
  logic          sendedRise, sendedFall, receivedRise, receivedFall;
  logic          curIsStart, bufWe;
  logic [7:0]    curByte;

  assign accept       = cmd_valid && (state_q == ST_IDLE);
  assign lenBad       = (cmd_len == '0) || (int'(cmd_len) > MAX_LEN);
  assign sendedRise   = sended && !sended_q;
  assign sendedFall   = !sended && sended_q;
  assign receivedRise = received && !received_q;
  assign receivedFall = !received && received_q;
  assign lastByte     = (ptr_q == 2'd2);
  assign waitState    = (state_q == ST_WAIT_RDY) || (state_q == ST_TX_ACC) ||
                        (state_q == ST_TX_REL)   || (state_q == ST_RX_ACC) ||
                        (state_q == ST_RX_REL);
  assign timedOut     = waitState && (toCnt_q >= TIMEOUT);

  // Byte list: address+W, register, then either write data or address+R restart.
  always_comb begin
    curByte    = '0;
    curIsStart = 1'b0;
    case (ptr_q)
      2'd0: begin
        curByte    = addrByte(DEV_ADDR, WRITE_BIT);
        curIsStart = START_BIT;
      end
      2'd1: curByte = cmdReg_q;
      2'd2: begin
        curByte    = cmdWrite_q ? cmdWdata_q : addrByte(DEV_ADDR, READ_BIT);
        curIsStart = cmdWrite_q ? 1'b0 : RESTART_BIT;
      end
      default: curByte = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    rxCount_d = rxCount_q;
    err_d     = err_q;
    holdCnt_d = holdCnt_q;
    bufWe     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d = 1'b0;
          idx_d = '0;
          ptr_d = '0;
          if (!cmd_write && lenBad) begin
            err_d     = 1'b1;
            rxCount_d = '0;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_WAIT_RDY;
          end
        end
      end
      ST_WAIT_RDY: if (isReady) state_d = ST_PRESENT;
      ST_PRESENT: begin
        holdCnt_d = '0;
        state_d   = ST_TX_ACC;
      end
      ST_TX_ACC: begin
        if (sendedRise) begin
          state_d = ST_TX_REL;
        end else if (holdCnt_q < 16'(START_HOLD)) begin
          holdCnt_d = holdCnt_q + 16'd1;
        end
      end
      ST_TX_REL: begin
        if (sendedFall) begin
          if (!lastByte) begin
            ptr_d   = ptr_q + 2'd1;
            state_d = ST_SEND_REQ;
          end else if (cmdWrite_q) begin
            rxCount_d = idx_q;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_RX_ACC;
          end
        end
      end
      ST_SEND_REQ: state_d = ST_PRESENT;
      ST_RX_ACC: begin
        if (receivedRise) begin
          bufWe   = 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = ST_RX_REL;
        end
      end
      ST_RX_REL: begin
        if (receivedFall) begin
          if (idx_q < len_q) begin
            state_d = ST_RX_REQ;
          end else begin
            rxCount_d = idx_q;
            state_d   = ST_DONE;
          end
        end
      end
      ST_RX_REQ: state_d = ST_RX_ACC;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Expiry overrides any handshake event seen in the same cycle.
    if (timedOut) begin
      state_d   = ST_DONE;
      err_d     = 1'b1;
      rxCount_d = idx_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      bufWe     = 1'b0;
    end
  end

  always_comb begin
    toCnt_d = '0;
    if ((state_d == state_q) && waitState) begin
      toCnt_d = toCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      rxCount_q  <= '0;
      err_q      <= 1'b0;
      holdCnt_q  <= '0;
      toCnt_q    <= '0;
      sended_q   <= 1'b0;
      received_q <= 1'b0;
      cmdWrite_q <= 1'b0;
      cmdReg_q   <= '0;
      cmdWdata_q <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      rxCount_q  <= rxCount_d;
      err_q      <= err_d;
      holdCnt_q  <= holdCnt_d;
      toCnt_q    <= toCnt_d;
      sended_q   <= sended;
      received_q <= received;
      if (accept) begin
        cmdWrite_q <= cmd_write;
        cmdReg_q   <= cmd_reg;
        cmdWdata_q <= cmd_wdata;
        len_q      <= cmd_len;
      end
    end
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done      = (state_q == ST_DONE);
    send      = (state_q == ST_SEND_REQ);
    receive   = (state_q == ST_RX_REQ);
    datasend  = '0;
    start     = 1'b0;
    if ((state_q == ST_PRESENT) || (state_q == ST_TX_ACC) || (state_q == ST_TX_REL)) begin
      datasend = curByte;
    end
    if (curIsStart) begin
      start = (state_q == ST_PRESENT) ||
              ((state_q == ST_TX_ACC) && (holdCnt_q < 16'(START_HOLD)) && !sendedRise);
    end
  end

  assign err      = err_q;
  assign rx_count = rxCount_q;

  i2c_rx_buf #(
    .MAX_LEN(MAX_LEN),
    .LW     (LW)
  ) u_buf (
    .clk    (clk),
    .clr_i  (reset),
    .we_i   (bufWe),
    .waddr_i(idx_q),
    .wdata_i(datareceive),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

endmodule
